// File: rtl/reg_bank_arbiter_pkg.sv
// reg_bank_arbiter_pkg: shared state encoding, parameter defaults and width helper
package reg_bank_arbiter_pkg;
  localparam int DEF_NREQ  = 4;
  localparam int DEF_NREGS = 8;
  localparam int DEF_AW    = 3;
  localparam int DEF_DW    = 32;
  typedef enum logic {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_t;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/reg_bank_arbiter_if.sv
// reg_bank_arbiter_if: request/grant/read-return bundle between masters and the bank arbiter
interface reg_bank_arbiter_if
  import reg_bank_arbiter_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int AW   = DEF_AW,
  parameter int DW   = DEF_DW
) ();
  localparam int OW = idx_w(NREQ);
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    we;
  logic [NREQ-1:0]    lock;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*DW-1:0] wdata;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    rvalid;
  logic [DW-1:0]      rdata;
  logic [OW-1:0]      owner;
  modport master (output req, we, lock, addr, wdata, input gnt, rvalid, rdata, owner);
  modport slave  (input req, we, lock, addr, wdata, output gnt, rvalid, rdata, owner);
endinterface

// File: rtl/reg_bank_arbiter_reg32_en.sv
// reg32_en: one bank register with synchronous reset and write enable
module reg32_en #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          res,
  input  logic          i_en,
  input  logic [DW-1:0] i_d,
  output logic [DW-1:0] o_q
);
  logic [DW-1:0] r_q;
  // load on enable, clear on reset
  always_ff @(posedge clk)
    if (res) r_q <= '0;
    else if (i_en) r_q <= i_d;
  assign o_q = r_q;
endmodule

// File: rtl/reg_bank_arbiter.sv
// reg_bank_arbiter: round-robin arbitrated, lockable access to a bank of registers
module reg_bank_arbiter
  import reg_bank_arbiter_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int NREGS = DEF_NREGS,
  parameter int AW    = DEF_AW,
  parameter int DW    = DEF_DW
) (
  input logic               clk,
  input logic               res,
  reg_bank_arbiter_if.slave bus
);
  localparam int OW = idx_w(NREQ);
  state_t          r_state, w_next;
  logic [OW-1:0]   r_ptr, r_owner, w_idx, w_cand;
  logic            w_any, w_hit, w_wr;
  logic [NREQ-1:0] w_gnt, w_rd_gnt, r_rvalid;
  logic [AW-1:0]   w_addr;
  logic [DW-1:0]   w_wdata, w_rd, r_rdata;
  logic [DW-1:0]   w_bank [NREGS];
  // pick the granted requester: locked owner only, else first pending after the last grant
  always_comb begin
    w_idx = r_owner;
    w_cand = '0;
    w_any = 1'b0;
    if (r_state == ST_LOCKED) w_any = bus.req[r_owner];
    else
      for (int k = 1; k <= NREQ; k++) begin
        w_cand = OW'((int'(r_ptr) + k) % NREQ);
        if (!w_any && bus.req[w_cand]) begin
          w_any = 1'b1;
          w_idx = w_cand;
        end
      end
    if (res) w_any = 1'b0;
  end
  assign w_gnt    = w_any ? NREQ'(1) << w_idx : '0;
  assign w_rd_gnt = w_gnt & ~bus.we;
  assign w_addr   = AW'(bus.addr >> (w_idx * AW));
  assign w_wdata  = DW'(bus.wdata >> (w_idx * DW));
  assign w_hit    = int'(w_addr) < NREGS;
  assign w_wr     = w_any && bus.we[w_idx] && w_hit;
  assign w_rd     = w_hit ? w_bank[w_addr] : '0;
  for (genvar r = 0; r < NREGS; r++) begin : g_reg
    reg32_en #(.DW(DW)) u_reg (
      .clk  (clk),
      .res  (res),
      .i_en (w_wr && w_addr == AW'(r)),
      .i_d  (w_wdata),
      .o_q  (w_bank[r])
    );
  end
  // the bank stays locked only while each granted access keeps its lock bit set
  always_comb w_next = (w_any && bus.lock[w_idx]) ? ST_LOCKED : ST_IDLE;
  // arbitration state: requester 0 is first in line after reset
  always_ff @(posedge clk)
    if (res) begin
      r_state <= ST_IDLE;
      r_ptr   <= OW'(NREQ - 1);
      r_owner <= '0;
    end else begin
      r_state <= w_next;
      if (w_any) begin
        r_ptr   <= w_idx;
        r_owner <= w_idx;
      end
    end
  // read return: one-cycle rvalid pulse, rdata held between reads
  always_ff @(posedge clk)
    if (res) begin
      r_rvalid <= '0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= w_rd_gnt;
      if (|w_rd_gnt) r_rdata <= w_rd;
    end
  assign bus.gnt    = w_gnt;
  assign bus.rvalid = r_rvalid;
  assign bus.rdata  = r_rdata;
  assign bus.owner  = r_owner;
endmodule

// File: tb/tb_reg_bank_arbiter.sv
// tb_reg_bank_arbiter: directed and randomized checks of reg_bank_arbiter against a behavioural model
module tb_reg_bank_arbiter;
  localparam int NREQ = 4, NREGS = 6, AW = 3, DW = 32;
  logic clk = 1'b0;
  logic res = 1'b1;
  int checks = 0;
  int errors = 0;
  reg_bank_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();
  reg_bank_arbiter #(.NREQ(NREQ), .NREGS(NREGS), .AW(AW), .DW(DW)) dut (
    .clk (clk),
    .res (res),
    .bus (bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic set(input int i, input logic r, input logic w, input logic l, input int ad, input logic [31:0] d);
    bus.req[i] = r;
    bus.we[i] = w;
    bus.lock[i] = l;
    bus.addr[i*AW +: AW] = AW'(ad);
    bus.wdata[i*DW +: DW] = d;
  endtask
  logic [DW-1:0]   m_mem [NREGS];
  logic            m_lock = 1'b0;
  int              m_owner = 0;
  int              m_ptr = NREQ - 1;
  logic [NREQ-1:0] m_rvalid = '0;
  logic [DW-1:0]   m_rdata = '0;
  bit              started = 1'b0;
  always @(negedge clk) begin
    int g;
    int a;
    g = -1;
    if (started) begin
      chk("m_rvalid", 32'(bus.rvalid), 32'(m_rvalid));
      chk("m_rdata", bus.rdata, m_rdata);
      chk("m_owner", 32'(bus.owner), m_owner);
    end
    if (!res) begin
      if (m_lock) g = ((bus.req >> m_owner) & 1) != 0 ? m_owner : -1;
      else
        for (int k = 1; k <= NREQ; k++)
          if (g < 0 && ((bus.req >> ((m_ptr + k) % NREQ)) & 1) != 0) g = (m_ptr + k) % NREQ;
    end
    chk("m_gnt", 32'(bus.gnt), g < 0 ? 32'd0 : 32'd1 << g);
    if (res) begin
      foreach (m_mem[j]) m_mem[j] = '0;
      m_lock = 1'b0;
      m_owner = 0;
      m_ptr = NREQ - 1;
      m_rvalid = '0;
      m_rdata = '0;
      started = 1'b1;
    end else begin
      m_rvalid = '0;
      m_lock = 1'b0;
      if (g >= 0) begin
        a = int'(AW'(bus.addr >> (g * AW)));
        if (((bus.we >> g) & 1) != 0) begin
          if (a < NREGS) m_mem[a] = DW'(bus.wdata >> (g * DW));
        end else begin
          m_rvalid = NREQ'(1) << g;
          m_rdata = a < NREGS ? m_mem[a] : '0;
        end
        m_ptr = g;
        m_owner = g;
        m_lock = ((bus.lock >> g) & 1) != 0;
      end
    end
  end
  initial begin
    logic [NREQ-1:0] g;
    bus.req = '0;
    bus.we = '0;
    bus.lock = '0;
    bus.addr = '0;
    bus.wdata = '0;
    @(negedge clk);
    chk("rst_gnt", 32'(bus.gnt), 0);
    tick();
    @(negedge clk);
    chk("rst_gnt2", 32'(bus.gnt), 0);
    chk("rst_rvalid", 32'(bus.rvalid), 0);
    chk("rst_rdata", bus.rdata, 0);
    tick(); res = 1'b0; set(0, 1, 0, 0, 5, 0);
    @(negedge clk);
    chk("rd5_gnt", 32'(bus.gnt), 1);
    tick(); set(0, 1, 1, 0, 3, 32'hDEADBEEF);
    @(negedge clk);
    chk("rd5_rvalid", 32'(bus.rvalid), 1);
    chk("rd5_rdata", bus.rdata, 0);
    chk("wr3_gnt", 32'(bus.gnt), 1);
    tick(); set(0, 1, 0, 0, 3, 0);
    @(negedge clk);
    chk("rd3_gnt", 32'(bus.gnt), 1);
    tick(); set(0, 1, 1, 0, 7, 32'h12345678);
    @(negedge clk);
    chk("rd3_rvalid", 32'(bus.rvalid), 1);
    chk("rd3_rdata", bus.rdata, 32'hDEADBEEF);
    chk("wr7_gnt", 32'(bus.gnt), 1);
    tick(); set(0, 1, 0, 0, 7, 0);
    @(negedge clk);
    chk("rd7_gnt", 32'(bus.gnt), 1);
    tick(); set(0, 0, 0, 0, 0, 0); set(3, 1, 0, 0, 1, 0);
    @(negedge clk);
    chk("rd7_rvalid", 32'(bus.rvalid), 1);
    chk("rd7_rdata", bus.rdata, 0);
    chk("pre_rr_gnt", 32'(bus.gnt), 8);
    for (int k = 0; k < 8; k++) begin
      tick();
      if (k == 0) for (int i = 0; i < NREQ; i++) set(i, 1, 0, 0, i, 0);
      @(negedge clk);
      chk("rr_gnt", 32'(bus.gnt), 32'd1 << (k % 4));
    end
    tick(); for (int i = 0; i < NREQ; i++) set(i, 0, 0, 0, 0, 0);
    set(1, 1, 1, 1, 0, 32'hA0); set(2, 1, 0, 0, 0, 0);
    @(negedge clk);
    chk("lk_gnt0", 32'(bus.gnt), 2);
    tick(); set(1, 1, 1, 1, 1, 32'hA1);
    @(negedge clk);
    chk("lk_gnt1", 32'(bus.gnt), 2);
    tick(); set(1, 1, 1, 0, 2, 32'hA2);
    @(negedge clk);
    chk("lk_gnt2", 32'(bus.gnt), 2);
    tick(); set(1, 0, 0, 0, 0, 0); set(0, 1, 0, 0, 0, 0); set(3, 1, 0, 0, 1, 0);
    @(negedge clk);
    chk("lk_after2", 32'(bus.gnt), 4);
    tick(); set(2, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("lk_after3", 32'(bus.gnt), 8);
    chk("lk_rdata", bus.rdata, 32'hA0);
    tick(); set(3, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("lk_after0", 32'(bus.gnt), 1);
    tick(); set(0, 1, 0, 0, 1, 0); set(2, 1, 0, 1, 2, 0);
    @(negedge clk);
    chk("ab_lock_gnt", 32'(bus.gnt), 4);
    tick(); set(2, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("ab_nogrant", 32'(bus.gnt), 0);
    tick();
    @(negedge clk);
    chk("ab_gnt0", 32'(bus.gnt), 1);
    chk("ab_owner", 32'(bus.owner), 2);
    tick(); set(0, 0, 0, 0, 0, 0); set(3, 1, 0, 1, 3, 0);
    @(negedge clk);
    chk("rm_gnt3", 32'(bus.gnt), 8);
    tick(); res = 1'b1; set(3, 1, 0, 1, 4, 0);
    @(negedge clk);
    chk("rm_res_gnt", 32'(bus.gnt), 0);
    tick(); res = 1'b0; set(0, 1, 0, 0, 3, 0); set(3, 1, 0, 0, 3, 0);
    @(negedge clk);
    chk("rm_rvalid", 32'(bus.rvalid), 0);
    chk("rm_gnt0", 32'(bus.gnt), 1);
    tick(); set(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("rm_gnt3b", 32'(bus.gnt), 8);
    chk("rm_rdata", bus.rdata, 0);
    tick(); set(3, 0, 0, 0, 0, 0);
    for (int k = 0; k < 8; k++) begin
      tick(); set(0, 1, 0, 0, k, 0);
      @(negedge clk);
      chk("clr_gnt", 32'(bus.gnt), 1);
      if (k > 0) begin
        chk("clr_rvalid", 32'(bus.rvalid), 1);
        chk("clr_rdata", bus.rdata, 0);
      end
    end
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      g = bus.gnt;
      tick();
      res = ($urandom_range(0, 149) == 0);
      for (int i = 0; i < NREQ; i++)
        if (g[i] || !bus.req[i]) begin
          if ($urandom_range(0, 99) < (g[i] ? 60 : 25))
            set(i, 1, 1'($urandom_range(0, 1)), $urandom_range(0, 99) < 35, $urandom_range(0, 7), $urandom);
          else
            set(i, 0, 0, 0, 0, 0);
        end
    end
    tick(); res = 1'b0; bus.req = '0;
    @(negedge clk);
    tick();
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
